// File: rtl/h_row_feeder_if.sv
// h_row_feeder_if
//   Bundles the H-row feeder's frame control, H source-memory read port,
//   sort-stage load/select signals and downstream row handshake.
//   master : the feeder (drives src_rd/src_addr, en_load/H_to_sort,
//            count_storage, q_vld, busy, done, err)
//   slave  : the surrounding environment (drives start, src_data/src_vld,
//            f_en_load, f_sort0, q_rdy)
interface h_row_feeder_if #(
   parameter int IDX_W   = 14,
   parameter int ROW_ENT = 35
);
   logic                       start;
   logic                       src_rd;
   logic [3:0]                 src_addr;
   logic [IDX_W*ROW_ENT-1:0]   src_data;
   logic                       src_vld;
   logic                       en_load;
   logic [IDX_W*ROW_ENT-1:0]   H_to_sort;
   logic                       f_en_load;
   logic                       f_sort0;
   logic [4:0]                 count_storage;
   logic                       q_vld;
   logic                       q_rdy;
   logic                       busy;
   logic                       done;
   logic                       err;

   modport master (
      input  start, src_data, src_vld, f_en_load, f_sort0, q_rdy,
      output src_rd, src_addr, en_load, H_to_sort, count_storage,
             q_vld, busy, done, err
   );

   modport slave (
      output start, src_data, src_vld, f_en_load, f_sort0, q_rdy,
      input  src_rd, src_addr, en_load, H_to_sort, count_storage,
             q_vld, busy, done, err
   );
endinterface

// File: rtl/h_row_feeder.sv
// h_row_feeder
//   Producer-side controller for the LDPC H-row sorting stage. Per frame it
//   fetches the 16 QC rows from the H source memory (one outstanding read),
//   buffers them, streams them to the sort stage in a 16-cycle en_load burst,
//   waits for the sort-complete pulse and then walks count_storage 0..15 so
//   downstream takes one sorted row per q_vld/q_rdy handshake.
//
// Ports
//   clk, rst_n  clock; asynchronous active-low reset
//   bus         h_row_feeder_if.master:
//                 start/busy/done/err           frame control and status
//                 src_rd/src_addr/src_data/src_vld   H source read port
//                 en_load/H_to_sort/f_en_load   row load into the sort stage
//                 f_sort0/count_storage         sort complete / row select
//                 q_vld/q_rdy                   downstream row handshake
//
// Build option
//   SORT_TIMEOUT_EN  when defined, an 8-bit watchdog aborts WAIT_SORT after
//                    TIMEOUT cycles without f_sort0 (sets err, no done).
//                    Otherwise err reports only a truncated load burst.
module h_row_feeder #(
   parameter int IDX_W   = 14,
   parameter int ROW_ENT = 35,
   parameter int ROWS    = 16,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   h_row_feeder_if.master bus
);
   localparam int         DW       = IDX_W * ROW_ENT;
   localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
   localparam logic [4:0] CS_NONE  = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      WAIT_SORT,
      DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      r_q, r_d;          // row being fetched
   logic [3:0]      k_q, k_d;          // next row to present in the burst
   logic            pend_q, pend_d;    // a read is outstanding
   logic            rd_q, rd_d;
   logic [3:0]      addr_q, addr_d;
   logic            en_q, en_d;
   logic [DW-1:0]   h_q, h_d;
   logic [4:0]      cs_q, cs_d;
   logic            qv_q, qv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            buf_we;

   logic [DW-1:0]   row_buf [ROWS];

`ifdef SORT_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
   logic [7:0]      wd_q, wd_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`endif

   // Row buffer holds frame data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (buf_we) row_buf[r_q] <= bus.src_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         r_q     <= '0;
         k_q     <= '0;
         pend_q  <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         h_q     <= '0;
         cs_q    <= CS_NONE;
         qv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         k_q     <= k_d;
         pend_q  <= pend_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         h_q     <= h_d;
         cs_q    <= cs_d;
         qv_q    <= qv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      k_d     = k_q;
      pend_d  = pend_q;
      rd_d    = 1'b0;
      addr_d  = addr_q;
      en_d    = 1'b0;
      h_d     = h_q;
      cs_d    = cs_q;
      qv_d    = qv_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      buf_we  = 1'b0;
`ifdef SORT_TIMEOUT_EN
      wd_d    = wd_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FETCH;
               busy_d  = 1'b1;
               r_d     = '0;
               rd_d    = 1'b1;
               addr_d  = '0;
            end
         end

         FETCH: begin
            // The read counts as outstanding only once its strobe has been
            // on the bus, so a src_vld coinciding with src_rd is ignored.
            if (rd_q) pend_d = 1'b1;
            if (pend_q && bus.src_vld) begin
               buf_we = 1'b1;
               pend_d = 1'b0;
               if (r_q == LAST_ROW) begin
                  state_d = LOAD;
                  en_d    = 1'b1;
                  h_d     = row_buf[0];
                  k_d     = 4'd1;
               end else begin
                  r_d    = r_q + 4'd1;
                  rd_d   = 1'b1;
                  addr_d = r_q + 4'd1;
               end
            end
         end

         LOAD: begin
            // k_q wraps to 0 once row 15 has been presented.
            if (en_q && bus.f_en_load) begin
               state_d = WAIT_SORT;
               err_d   = 1'b1;
               k_d     = '0;
`ifdef SORT_TIMEOUT_EN
               wd_d    = '0;
`endif
            end else if (k_q == '0) begin
               state_d = WAIT_SORT;
`ifdef SORT_TIMEOUT_EN
               wd_d    = '0;
`endif
            end else begin
               en_d = 1'b1;
               h_d  = row_buf[k_q];
               k_d  = k_q + 4'd1;
            end
         end

         WAIT_SORT: begin
            if (bus.f_sort0) begin
               state_d = DRAIN;
               cs_d    = '0;
               qv_d    = 1'b1;
            end
`ifdef SORT_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               wd_d = wd_q + 8'd1;
            end
`endif
         end

         DRAIN: begin
            if (qv_q && bus.q_rdy) begin
               if (cs_q == {1'b0, LAST_ROW}) begin
                  state_d = IDLE;
                  cs_d    = CS_NONE;
                  qv_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cs_d = cs_q + 5'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.src_rd        = rd_q;
   assign bus.src_addr      = addr_q;
   assign bus.en_load       = en_q;
   assign bus.H_to_sort     = h_q;
   assign bus.count_storage = cs_q;
   assign bus.q_vld         = qv_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
endmodule

// File: tb/tb_h_row_feeder.sv
// tb_h_row_feeder
//   Directed bench for h_row_feeder: a latency-configurable H source model
//   serves reads with row r = all indices equal r; the main sequence runs
//   frames covering fixed/random latency, q_rdy patterns, ignored start and
//   f_sort0, load truncation, the WAIT_SORT behaviour of the build, and an
//   asynchronous reset during DRAIN.
module tb_h_row_feeder;
   localparam int IDX_W   = 14;
   localparam int ROW_ENT = 35;
   localparam int DW      = IDX_W * ROW_ENT;
   typedef logic [DW-1:0] val_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   lat_mode;      // 0 = random 1..5, otherwise fixed latency
   int   extra_rd;      // src_rd seen while a read was outstanding
   logic [3:0] rd_addrs [$];

   h_row_feeder_if #(.IDX_W(IDX_W), .ROW_ENT(ROW_ENT)) bus ();

   h_row_feeder #(
      .IDX_W   (IDX_W),
      .ROW_ENT (ROW_ENT),
      .ROWS    (16),
      .TIMEOUT (255)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic val_t row_val(input int r);
      val_t v;
      v = '0;
      for (int unsigned i = 0; i < ROW_ENT; i++) v[i*IDX_W +: IDX_W] = IDX_W'(r);
      return v;
   endfunction

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_src_rd"},  val_t'(bus.src_rd), val_t'(0));
      check({tag, "_src_addr"}, val_t'(bus.src_addr), val_t'(0));
      check({tag, "_en_load"}, val_t'(bus.en_load), val_t'(0));
      check({tag, "_h"},       bus.H_to_sort, val_t'(0));
      check({tag, "_cs"},      val_t'(bus.count_storage), val_t'(5'h1f));
      check({tag, "_q_vld"},   val_t'(bus.q_vld), val_t'(0));
      check({tag, "_busy"},    val_t'(bus.busy), val_t'(0));
      check({tag, "_done"},    val_t'(bus.done), val_t'(0));
      check({tag, "_err"},     val_t'(bus.err), val_t'(0));
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check_reset(tag);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // H source memory model.
   initial begin : src_model
      logic [3:0] a;
      int lat;
      bus.src_vld  = 1'b0;
      bus.src_data = '0;
      forever begin
         @(posedge clk);
         #1;
         while (bus.src_rd === 1'b1) begin
            a = bus.src_addr;
            rd_addrs.push_back(a);
            lat = (lat_mode == 0) ? int'($urandom_range(5, 1)) : lat_mode;
            repeat (lat) begin
               @(posedge clk);
               #1;
               if (bus.src_rd) extra_rd++;
            end
            bus.src_vld  = 1'b1;
            bus.src_data = row_val(int'(a));
            @(posedge clk);
            #1;
            bus.src_vld  = 1'b0;
         end
      end
   end

   task automatic start_frame();
      rd_addrs.delete();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("start_busy", val_t'(bus.busy), val_t'(1));
      check("start_rd", val_t'(bus.src_rd), val_t'(1));
      check("start_addr", val_t'(bus.src_addr), val_t'(0));
   endtask

   task automatic fetch_and_burst(input bit sort_in_fetch, input bit start_in_load,
                                  input int trunc_at);
      bit seen;
      int n;
      seen = 1'b0;
      for (int unsigned w = 0; w < 400; w++) begin
         if (bus.en_load) begin
            seen = 1'b1;
            break;
         end
         bus.f_sort0 = sort_in_fetch && (w == 5);
         @(posedge clk);
         #1;
      end
      bus.f_sort0 = 1'b0;
      check("load_seen", val_t'(seen), val_t'(1));
      if (!seen) return;
      n = 0;
      while (bus.en_load && n < 20) begin
         check("h_row", bus.H_to_sort, row_val(n));
         bus.start     = start_in_load && (n == 5);
         bus.f_en_load = (trunc_at == n);
         @(posedge clk);
         #1;
         n++;
      end
      bus.start     = 1'b0;
      bus.f_en_load = 1'b0;
      check("burst_len", val_t'(n), val_t'((trunc_at >= 0) ? trunc_at + 1 : 16));
      check("err_after_load", val_t'(bus.err), val_t'(trunc_at >= 0));
      check("rd_count", val_t'(rd_addrs.size()), val_t'(16));
      foreach (rd_addrs[i]) check("rd_addr", val_t'(rd_addrs[i]), val_t'(i));
      check("rd_overlap", val_t'(extra_rd), val_t'(0));
   endtask

   // Entered at the first WAIT_SORT cycle; f_sort0 is pulsed in the
   // delay-th WAIT_SORT cycle.
   task automatic sort_and_drain(input int delay, input bit qpat, input bit rst_in_drain);
      bit pat [4];
      bit acc;
      bit finished;
      int exp;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 1; i < delay; i++) begin
         @(posedge clk);
         #1;
      end
      check("wait_busy", val_t'(bus.busy), val_t'(1));
      check("wait_q_vld", val_t'(bus.q_vld), val_t'(0));
      check("wait_cs", val_t'(bus.count_storage), val_t'(5'h1f));
      bus.f_sort0 = 1'b1;
      @(posedge clk);
      #1;
      bus.f_sort0 = 1'b0;
      exp = 0;
      finished = 1'b0;
      for (int unsigned i = 0; i < 200; i++) begin
         check("drain_cs", val_t'(bus.count_storage), val_t'(exp));
         check("drain_q_vld", val_t'(bus.q_vld), val_t'(1));
         if (rst_in_drain && exp == 6) begin
            bus.q_rdy = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check_reset("rst_drain");
            @(posedge clk);
            #3 rst_n = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
         acc = qpat ? pat[i % 4] : 1'b1;
         bus.q_rdy = acc;
         @(posedge clk);
         #1;
         if (acc) begin
            if (exp == 15) begin
               finished = 1'b1;
               break;
            end
            exp++;
         end
      end
      bus.q_rdy = 1'b0;
      check("drain_finished", val_t'(finished), val_t'(1));
      check("end_cs", val_t'(bus.count_storage), val_t'(5'h1f));
      check("end_q_vld", val_t'(bus.q_vld), val_t'(0));
      check("end_busy", val_t'(bus.busy), val_t'(0));
      check("end_done", val_t'(bus.done), val_t'(1));
      @(posedge clk);
      #1;
      check("post_done", val_t'(bus.done), val_t'(0));
      check("post_busy", val_t'(bus.busy), val_t'(0));
      check("post_src_rd", val_t'(bus.src_rd), val_t'(0));
   endtask

`ifdef SORT_TIMEOUT_EN
   task automatic watchdog_run();
      int cnt;
      bit saw_done;
      cnt = 0;
      saw_done = 1'b0;
      while (bus.busy && cnt < 400) begin
         if (bus.done) saw_done = 1'b1;
         @(posedge clk);
         #1;
         cnt++;
      end
      check("wd_cycles", val_t'(cnt), val_t'(255));
      check("wd_err", val_t'(bus.err), val_t'(1));
      check("wd_busy", val_t'(bus.busy), val_t'(0));
      check("wd_done", val_t'(bus.done), val_t'(0));
      check("wd_saw_done", val_t'(saw_done), val_t'(0));
      @(posedge clk);
      #1;
      check("wd_err_sticky", val_t'(bus.err), val_t'(1));
   endtask
`endif

   initial begin : main
      n_checks      = 0;
      n_pass        = 0;
      lat_mode      = 1;
      extra_rd      = 0;
      rst_n         = 1'b1;
      bus.start     = 1'b0;
      bus.f_en_load = 1'b0;
      bus.f_sort0   = 1'b0;
      bus.q_rdy     = 1'b0;
      #2;
      do_reset("rst_init");

      lat_mode = 1;
      start_frame();
      fetch_and_burst(1'b0, 1'b0, -1);
      sort_and_drain(40, 1'b0, 1'b0);

      lat_mode = 0;
      start_frame();
      fetch_and_burst(1'b0, 1'b0, -1);
      sort_and_drain(40, 1'b1, 1'b0);

      lat_mode = 2;
      start_frame();
      fetch_and_burst(1'b1, 1'b1, -1);
      sort_and_drain(40, 1'b1, 1'b0);

      lat_mode = 1;
      start_frame();
      fetch_and_burst(1'b0, 1'b0, 3);
      sort_and_drain(5, 1'b0, 1'b0);
      check("trunc_err_sticky", val_t'(bus.err), val_t'(1));
      do_reset("rst_after_trunc");

`ifdef SORT_TIMEOUT_EN
      start_frame();
      fetch_and_burst(1'b0, 1'b0, -1);
      watchdog_run();
      do_reset("rst_after_wd");
`else
      start_frame();
      fetch_and_burst(1'b0, 1'b0, -1);
      sort_and_drain(300, 1'b0, 1'b0);
      check("long_wait_err", val_t'(bus.err), val_t'(0));
`endif

      lat_mode = 3;
      start_frame();
      fetch_and_burst(1'b0, 1'b0, -1);
      sort_and_drain(40, 1'b1, 1'b1);

      lat_mode = 1;
      start_frame();
      fetch_and_burst(1'b0, 1'b0, -1);
      sort_and_drain(10, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : global_limit
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "time limit");
   end
endmodule
